seq_det_param: RTL and testbench

Parametrised serial pattern detector FSM: the generalised successor of the team's fixed 2-bit minimised detector automata. It samples a 1-bit serial input under an enable and compares the most recent PAT_W accepted bits against a run-time loadable pattern. It provides a Mealy match output, a registered match output, overlapping or non-overlapping detection, and an optional saturating hit counter. It sits in the automate test designs between a serial stimulus source and the LED/debug outputs.

---
 rtl/seq_det_param.sv | 137 +++++++++++++
 tb/tb_seq_det_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_param.sv
// -----------------------------------------------------------------------------
// seq_det_param
//   Parametrised serial pattern detector. Accepted bits (under en) are shifted
//   into a short history and compared, together with the current bit, against
//   a run-time loadable pattern. Supports overlapping and non-overlapping
//   detection, a Mealy match and its registered copy.
//
//   Optional feature: define SEQ_DET_HITCNT_EN to build the saturating hit
//   counter. Without it hit_cnt and cnt_sat are tied to 0.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  pattern after reset, MSB is the oldest bit
//   CNT_W    hit counter width (2..16)
//
// Ports
//   clk      clock, rising edge
//   res      asynchronous active-high reset
//   en       accept x this cycle
//   x        serial data bit
//   ovl      1 = overlapping matches, 0 = non-overlapping
//   ld       load pat_in as the new pattern and restart detection
//   pat_in   new pattern, MSB is the oldest bit
//   match_m  Mealy match (combinational from registers and x/en/ld)
//   match_r  match_m registered one cycle
//   state    00 EMPTY, 01 FILL, 10 ARMED
//   hit_cnt  saturating hit count
//   cnt_sat  hit_cnt is all ones
// -----------------------------------------------------------------------------
module seq_det_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             x,
  input  logic             ovl,
  input  logic             ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             match_m,
  output logic             match_r,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b10
  } state_t;

  localparam int             FW   = $clog2(PAT_W);
  localparam logic [FW-1:0]  FULL = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pat, pat_nxt;
  logic [PAT_W-2:0] hist, hist_nxt;   // bit 0 is the newest accepted bit
  logic [FW-1:0]    fcnt, fcnt_nxt;   // accepted bits since restart, saturates at FULL
  logic [PAT_W-1:0] cand;
  logic             armed;
  state_t           state_q;

  function automatic state_t decode(input logic [FW-1:0] f);
    if (f == '0)        return EMPTY;
    else if (f == FULL) return ARMED;
    else                return FILL;
  endfunction

  assign cand    = {hist, x};
  assign armed   = (fcnt == FULL);
  // ld wins over en, so a bit presented together with a load never matches.
  assign match_m = en & ~ld & armed & (cand == pat);
  assign state   = state_q;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path can
    // leave it unassigned and infer a latch.
    pat_nxt  = pat;
    hist_nxt = hist;
    fcnt_nxt = fcnt;
    if (ld) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fcnt_nxt = '0;
    end else if (en) begin
      if (match_m && !ovl) begin
        // Non-overlapping: the matched bits are consumed, start over.
        hist_nxt = '0;
        fcnt_nxt = '0;
      end else begin
        hist_nxt = cand[PAT_W-2:0];
        if (!armed) fcnt_nxt = fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pat     <= PATTERN;
      hist    <= '0;
      fcnt    <= '0;
      state_q <= EMPTY;
      match_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pat     <= pat_nxt;
      hist    <= hist_nxt;
      fcnt    <= fcnt_nxt;
      state_q <= decode(fcnt_nxt);
      match_r <= match_m;
    end
  end

`ifdef SEQ_DET_HITCNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= '0;
    end else if (match_m && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_cnt = cnt_q;
  assign cnt_sat = &cnt_q;
`else
  assign hit_cnt = '0;
  assign cnt_sat = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// -----------------------------------------------------------------------------
// tb_seq_det_param
//   Directed bench for seq_det_param. Two instances share the stimulus: one
//   with CNT_W=8 and one with CNT_W=2 so counter saturation is reachable.
//   A window-based reference model is compared on every falling edge; the
//   directed sequences also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_seq_det_param;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PAT_RST = 4'b1011;
`ifdef SEQ_DET_HITCNT_EN
  localparam bit HC = 1'b1;
`else
  localparam bit HC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res, en, x, ovl, ld;
  logic [3:0] pat_in;
  logic       match_m, match_r, cnt_sat;
  logic [1:0] state;
  logic [7:0] hit_cnt;
  logic       match_m2, match_r2, cnt_sat2;
  logic [1:0] state2;
  logic [1:0] hit_cnt2;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  seq_det_param #(.PAT_W(PAT_W), .PATTERN(PAT_RST), .CNT_W(8)) dut (
    .clk(clk), .res(res), .en(en), .x(x), .ovl(ovl), .ld(ld), .pat_in(pat_in),
    .match_m(match_m), .match_r(match_r), .state(state),
    .hit_cnt(hit_cnt), .cnt_sat(cnt_sat)
  );

  seq_det_param #(.PAT_W(PAT_W), .PATTERN(PAT_RST), .CNT_W(2)) dut2 (
    .clk(clk), .res(res), .en(en), .x(x), .ovl(ovl), .ld(ld), .pat_in(pat_in),
    .match_m(match_m2), .match_r(match_r2), .state(state2),
    .hit_cnt(hit_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keeps the accepted bits since the last restart as a
  // window (oldest first) plus an unbounded count of them.
  // ---------------------------------------------------------------------------
  bit         hq[$];
  int         nacc;
  logic [3:0] mpat;
  int         cnt1, cnt2;
  bit         prev_m;

  function automatic logic [1:0] exp_state(input int n);
    if (n == 0)           return 2'b00;
    else if (n >= PAT_W-1) return 2'b10;
    else                  return 2'b01;
  endfunction

  function automatic bit model_match();
    logic [3:0] w;
    if (!en || ld || nacc < PAT_W-1) return 1'b0;
    w = {hq[hq.size()-3], hq[hq.size()-2], hq[hq.size()-1], x};
    return w == mpat;
  endfunction

  always @(negedge clk) begin
    bit em;
    if (res) begin
      hq.delete();
      nacc   = 0;
      mpat   = PAT_RST;
      cnt1   = 0;
      cnt2   = 0;
      prev_m = 1'b0;
      em     = 1'b0;
    end else begin
      em = model_match();
    end
    check("m_match_m",  match_m,  em);
    check("m_match_m2", match_m2, em);
    check("m_match_r",  match_r,  prev_m);
    check("m_match_r2", match_r2, prev_m);
    check("m_state",    state,    exp_state(nacc));
    check("m_state2",   state2,   exp_state(nacc));
    check("m_hit_cnt",  hit_cnt,  HC ? cnt1 : 0);
    check("m_hit_cnt2", hit_cnt2, HC ? cnt2 : 0);
    check("m_cnt_sat",  cnt_sat,  HC && cnt1 == 255);
    check("m_cnt_sat2", cnt_sat2, HC && cnt2 == 3);
    if (!res) begin
      prev_m = em;
      if (ld) begin
        mpat = pat_in;
        hq.delete();
        nacc = 0;
        cnt1 = 0;
        cnt2 = 0;
      end else if (en) begin
        if (em) begin
          if (cnt1 < 255) cnt1++;
          if (cnt2 < 3)   cnt2++;
        end
        if (em && !ovl) begin
          hq.delete();
          nacc = 0;
        end else begin
          hq.push_back(x);
          if (hq.size() > PAT_W-1) void'(hq.pop_front());
          nacc++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus. drive() is entered 1 time unit after a rising edge,
  // applies one cycle of inputs, checks match_m for that cycle, then checks
  // match_r and state after the edge. It returns 1 unit after that edge.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic xv, input logic ev, input logic lv,
                       input logic [3:0] pv, input logic em,
                       input logic er, input logic [1:0] es);
    x = xv; en = ev; ld = lv; pat_in = pv;
    #1;
    check("lit_match_m", match_m, em);
    @(posedge clk);
    #1;
    check("lit_match_r", match_r, er);
    check("lit_state",   state,   es);
  endtask

  task automatic check_hits(input int h);
    check("lit_hit_cnt",  hit_cnt,  HC ? h : 0);
    check("lit_hit_cnt2", hit_cnt2, HC ? ((h > 3) ? 3 : h) : 0);
    check("lit_cnt_sat2", cnt_sat2, HC && h >= 3);
  endtask

  initial begin
    logic [12:0] s;
    int hits;
    res = 1'b1; en = 1'b0; x = 1'b0; ovl = 1'b0; ld = 1'b0; pat_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_match_m", match_m, 1'b0);
    check("rst_match_r", match_r, 1'b0);
    check("rst_state",   state,   2'b00);
    check("rst_cnt_sat", cnt_sat, 1'b0);
    check_hits(0);
    res = 1'b0;

    // Overlap: 1,0,1,1,0,1,1 -> matches on bits 4 and 7.
    ovl = 1'b1;
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 1, 1, 2'b10);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 1, 1, 2'b10);
    drive(0, 1, 1, 4'b1011, 0, 0, 2'b00);

    // Non-overlap: same stream -> match on bit 4 only, then restart.
    ovl = 1'b0;
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 1, 1, 2'b00);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(0, 1, 1, 4'b1011, 0, 0, 2'b00);

    // Enable gap: 1,0,<3 idle cycles with x=1>,1,1 -> single match on bit 4.
    ovl = 1'b1;
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 0, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 0, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 0, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 1, 1, 2'b10);

    // Load: after 1,0,1 the history is 101, so x=1 would complete 1011;
    // the load must suppress it and install 0110.
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 1, 4'b0110, 0, 0, 2'b00);
    check_hits(0);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(0, 1, 0, 4'h0, 1, 1, 2'b10);

    // Reset between edges after 1,0,1; pattern returns to 1011.
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    en = 1'b0;
    #2 res = 1'b1;
    #1;
    check("res_match_m", match_m, 1'b0);
    check("res_match_r", match_r, 1'b0);
    check("res_state",   state,   2'b00);
    check_hits(0);
    @(posedge clk);
    #1 res = 1'b0;
    drive(1, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(0, 1, 0, 4'h0, 0, 0, 2'b01);
    drive(1, 1, 0, 4'h0, 0, 0, 2'b10);
    drive(1, 1, 0, 4'h0, 1, 1, 2'b10);

    // Reset while match_r is high: it must drop at once.
    en  = 1'b0;
    res = 1'b1;
    #1;
    check("res2_match_r", match_r, 1'b0);
    check("res2_state",   state,   2'b00);
    @(posedge clk);
    #1 res = 1'b0;

    // Counter: 1011011011011 overlapping -> matches on bits 4,7,10,13.
    ovl = 1'b1;
    drive(0, 1, 1, 4'b1011, 0, 0, 2'b00);
    check_hits(0);
    s    = 13'b1011011011011;
    hits = 0;
    for (int i = 12; i >= 0; i--) begin
      int  k;
      bit  m;
      k = 13 - i;
      m = (k >= 4) && (k % 3 == 1);
      drive(s[i], 1, 0, 4'h0, m, m, (k >= 3) ? 2'b10 : 2'b01);
      if (m) begin
        hits++;
        check_hits(hits);
      end
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
